// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell (two half adders + OR) and a
// carry flop process one operand bit per clock behind a start/busy/done handshake.

module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;

  logic ha0_s, ha0_c, ha1_c, bit_s, bit_c;

  // Full adder: first half adder combines the operand bits, second adds the carry.
  half_adder u_ha0 (.x_i(a_sr_q[0]), .y_i(b_sr_q[0]), .s_o(ha0_s), .c_o(ha0_c));
  half_adder u_ha1 (.x_i(ha0_s),     .y_i(carry_q),   .s_o(bit_s), .c_o(ha1_c));
  assign bit_c = ha0_c | ha1_c;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the shift chains depend on that ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are plain flops, not memory, so clearing
      // them here is cheap and keeps aborted operations from leaking state.
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          s_sr_q  <= {bit_s, s_sr_q[WIDTH-1:1]};
          carry_q <= bit_c;
          if (cnt_q == LAST) begin
            sum_q   <= {bit_s, s_sr_q[WIDTH-1:1]};
            cout_q  <= bit_c;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
